// File: rtl/reg_file_shadow_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_shadow_if
// Brief    : Bus bundle for reg_file_shadow (write port, two read ports,
//            save/restore commands and status). Signal prefixes are from the
//            register file's point of view.
// Revision : 1.0 - initial release
// ============================================================================
interface reg_file_shadow_if #(
  parameter int WIDTH = 16,
  parameter int AW    = 4
);
  logic             i_write;
  logic [AW-1:0]    i_write_addr;
  logic [WIDTH-1:0] i_write_data;
  logic [AW-1:0]    i_read_addr_a;
  logic [WIDTH-1:0] o_read_data_a;
  logic [AW-1:0]    i_read_addr_b;
  logic [WIDTH-1:0] o_read_data_b;
  logic             i_save;
  logic             i_restore;
  logic             o_busy;
  logic             o_done;

  modport slave (
    input  i_write, i_write_addr, i_write_data,
    input  i_read_addr_a, i_read_addr_b,
    input  i_save, i_restore,
    output o_read_data_a, o_read_data_b,
    output o_busy, o_done
  );

  modport master (
    output i_write, i_write_addr, i_write_data,
    output i_read_addr_a, i_read_addr_b,
    output i_save, i_restore,
    input  o_read_data_a, o_read_data_b,
    input  o_busy, o_done
  );
endinterface
`default_nettype wire

// File: rtl/reg_file_shadow.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_shadow
// Brief    : WIDTH x DEPTH register file, 1 write / 2 bypassed reads, with a
//            shadow bank copied one register per cycle by Save/Restore.
//            Optional macro ZERO_REG_EN hardwires register 0 to zero.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_shadow #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  reg_file_shadow_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SAVE    = 2'd1,
    S_RESTORE = 2'd2
  } state_t;

  localparam logic [AW:0]   c_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] c_LAST  = AW'(DEPTH - 1);

  state_t           r_state;
  logic [AW-1:0]    r_idx;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_main   [DEPTH];
  logic [WIDTH-1:0] r_shadow [DEPTH];

  logic             w_wr_hit;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  // Register 0 is treated as non-addressable when hardwired, which removes
  // it from writes and bypass in one place.
  function automatic logic addr_ok(input logic [AW-1:0] a);
`ifdef ZERO_REG_EN
    return ({1'b0, a} < c_DEPTH) && (a != '0);
`else
    return ({1'b0, a} < c_DEPTH);
`endif
  endfunction

  assign w_wr_hit = bus.i_write & ~r_busy & addr_ok(bus.i_write_addr);

  always_comb begin
    w_rd_a = '0;
    if (addr_ok(bus.i_read_addr_a)) begin
      if (w_wr_hit && (bus.i_write_addr == bus.i_read_addr_a))
        w_rd_a = bus.i_write_data;
      else
        w_rd_a = r_main[bus.i_read_addr_a];
    end
  end

  always_comb begin
    w_rd_b = '0;
    if (addr_ok(bus.i_read_addr_b)) begin
      if (w_wr_hit && (bus.i_write_addr == bus.i_read_addr_b))
        w_rd_b = bus.i_write_data;
      else
        w_rd_b = r_main[bus.i_read_addr_b];
    end
  end

  assign bus.o_read_data_a = w_rd_a;
  assign bus.o_read_data_b = w_rd_b;
  assign bus.o_busy        = r_busy;
  assign bus.o_done        = r_done;

  // Writes only land while IDLE and copies only run while busy, so the
  // main bank never sees two writers in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_main[i]   <= '0;
        r_shadow[i] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_idx <= '0;
          if (bus.i_save) begin
            r_state <= S_SAVE;
            r_busy  <= 1'b1;
          end else if (bus.i_restore) begin
            r_state <= S_RESTORE;
            r_busy  <= 1'b1;
          end
        end
        S_SAVE: begin
          r_shadow[r_idx] <= r_main[r_idx];
          r_idx           <= r_idx + AW'(1);
          if (r_idx == c_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        S_RESTORE: begin
`ifdef ZERO_REG_EN
          if (r_idx != '0)
            r_main[r_idx] <= r_shadow[r_idx];
`else
          r_main[r_idx] <= r_shadow[r_idx];
`endif
          r_idx <= r_idx + AW'(1);
          if (r_idx == c_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
      if (w_wr_hit)
        r_main[bus.i_write_addr] <= bus.i_write_data;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_shadow.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file_shadow
// Brief    : Directed self-checking bench for reg_file_shadow (DEPTH=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file_shadow;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
`ifdef ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;

  reg_file_shadow_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  reg_file_shadow #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
    bus.i_write      = 1'b1;
    bus.i_write_addr = a;
    bus.i_write_data = d;
    tick();
    bus.i_write = 1'b0;
  endtask

  task automatic read_a(input logic [AW-1:0] a, input string tag, input logic [WIDTH-1:0] exp);
    bus.i_read_addr_a = a;
    #1;
    check(tag, bus.o_read_data_a, exp);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!bus.o_done && k < 40) begin
      tick();
      k++;
    end
    check("done_seen", bus.o_done, 1);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n             = 1'b0;
    bus.i_write       = 1'b0;
    bus.i_write_addr  = '0;
    bus.i_write_data  = '0;
    bus.i_read_addr_a = 4'd3;
    bus.i_read_addr_b = 4'd3;
    bus.i_save        = 1'b0;
    bus.i_restore     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.o_busy, 0);
    check("rst_done", bus.o_done, 0);
    check("rst_rd", bus.o_read_data_a, 0);
    rst_n = 1'b1;
    tick();

    // Reset mid-cycle clears stored data immediately
    do_write(4'd3, 16'h1234);
    read_a(4'd3, "wr_r3", 16'h1234);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_rd", bus.o_read_data_a, 0);
    check("async_rst_busy", bus.o_busy, 0);
    check("async_rst_done", bus.o_done, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Bypass on both ports, then committed value
    bus.i_write       = 1'b1;
    bus.i_write_addr  = 4'd5;
    bus.i_write_data  = 16'hBEEF;
    bus.i_read_addr_a = 4'd5;
    bus.i_read_addr_b = 4'd5;
    #1;
    check("bypass_a", bus.o_read_data_a, 16'hBEEF);
    check("bypass_b", bus.o_read_data_b, 16'hBEEF);
    tick();
    bus.i_write = 1'b0;
    #1;
    check("stored_a", bus.o_read_data_a, 16'hBEEF);
    check("stored_b", bus.o_read_data_b, 16'hBEEF);

    // Load, save, count busy cycles
    for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 16'h0100 + 16'(i));
    bus.i_save = 1'b1;
    tick();
    bus.i_save = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      check("save_busy", bus.o_busy, 1);
      check("save_nodone", bus.o_done, 0);
      tick();
    end
    check("save_end_busy", bus.o_busy, 0);
    check("save_done", bus.o_done, 1);
    tick();
    check("save_done_pulse", bus.o_done, 0);

    // Clobber then restore
    for (int i = 0; i < DEPTH; i++) do_write(AW'(i), 16'hFFFF);
    read_a(4'd4, "clobber_r4", 16'hFFFF);
    bus.i_restore = 1'b1;
    tick();
    bus.i_restore = 1'b0;
    wait_done();
    for (int i = 0; i < DEPTH; i++)
      read_a(AW'(i), "restore_ri", (i == 0 && ZR) ? 16'h0000 : 16'h0100 + 16'(i));

    // Write and Restore while busy are ignored
    bus.i_save = 1'b1;
    tick();
    bus.i_save = 1'b0;
    check("blk_busy0", bus.o_busy, 1);
    for (int k = 1; k < DEPTH; k++) begin
      if (k == 3) begin
        bus.i_write       = 1'b1;
        bus.i_write_addr  = 4'd2;
        bus.i_write_data  = 16'hAAAA;
        bus.i_restore     = 1'b1;
        bus.i_read_addr_a = 4'd2;
        #1;
        check("no_bypass_busy", bus.o_read_data_a, 16'h0102);
      end
      tick();
      bus.i_write   = 1'b0;
      bus.i_restore = 1'b0;
      check("blk_busy", bus.o_busy, 1);
    end
    tick();
    check("blk_end_busy", bus.o_busy, 0);
    check("blk_done", bus.o_done, 1);
    tick();
    check("blk_no_restart", bus.o_busy, 0);
    read_a(4'd2, "blk_r2", 16'h0102);

    // Save wins over Restore
    do_write(4'd6, 16'h6666);
    bus.i_save    = 1'b1;
    bus.i_restore = 1'b1;
    tick();
    bus.i_save    = 1'b0;
    bus.i_restore = 1'b0;
    wait_done();
    do_write(4'd6, 16'h0000);
    read_a(4'd6, "prio_clobber", 16'h0000);
    bus.i_restore = 1'b1;
    tick();
    bus.i_restore = 1'b0;
    wait_done();
    read_a(4'd6, "prio_r6", 16'h6666);
    read_a(4'd5, "prio_r5", 16'h0105);

    // Abort a restore at idx=7
    for (int i = 8; i < DEPTH; i++) do_write(AW'(i), 16'h0000);
    bus.i_restore = 1'b1;
    tick();
    bus.i_restore = 1'b0;
    repeat (7) tick();
    read_a(4'd3, "partial_r3", 16'h0103);
    read_a(4'd10, "partial_r10", 16'h0000);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_busy", bus.o_busy, 0);
    check("abort_done", bus.o_done, 0);
    read_a(4'd3, "abort_r3", 16'h0000);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      check("abort_nodone", bus.o_done, 0);
      tick();
    end
    read_a(4'd6, "abort_r6", 16'h0000);
    bus.i_restore = 1'b1;
    tick();
    bus.i_restore = 1'b0;
    wait_done();
    read_a(4'd6, "abort_shadow_r6", 16'h0000);

    // Register 0 behaviour
    bus.i_write       = 1'b1;
    bus.i_write_addr  = 4'd0;
    bus.i_write_data  = 16'h5555;
    bus.i_read_addr_a = 4'd0;
    #1;
    check("r0_same_cycle", bus.o_read_data_a, ZR ? 16'h0000 : 16'h5555);
    tick();
    bus.i_write = 1'b0;
    #1;
    check("r0_after_edge", bus.o_read_data_a, ZR ? 16'h0000 : 16'h5555);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
`default_nettype wire
